// File: rtl/wbu_stage_pkg.sv
// Shared definitions for the write-back stage: write-back source select codes
// and the skid buffer state encoding.
package wbu_stage_pkg;

    localparam int unsigned WB_SEL_WIDTH = 2;

    localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_EXU  = 2'b00;
    localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_CSR  = 2'b11;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/wbu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The head register drives the output;
// the skid register absorbs the one extra entry accepted before in_ready drops.
module wbu_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    import wbu_stage_pkg::*;

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;
    logic             load_head_in;
    logic             load_head_skid;
    logic             load_skid;

    assign push      = in_valid & in_ready;
    assign out_valid = (state_q != SKID_EMPTY);
    assign pop       = out_valid & out_ready;
    assign out_data  = head_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and register load enables
    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (push) begin
                    load_head_in = 1'b1;
                    state_d      = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (push && pop) begin
                    load_head_in = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    state_d   = SKID_FULL;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (pop) begin
                    load_head_skid = 1'b1;
                    state_d        = SKID_ONE;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
    end

    // in_ready is registered from the next state so it drops right after the skid fills
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_ready <= 1'b1;
            head_q   <= '0;
            skid_q   <= '0;
        end else begin
            in_ready <= (state_d != SKID_FULL);
            if (load_head_in) begin
                head_q <= in_data;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/wbu_stage.sv
// Write-back stage: selects the write-back value, buffers retiring instructions
// in a skid buffer and drives the GPR write port and retire interface.
module wbu_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_wen,
    input  logic [1:0]        in_wb_sel,
    input  logic [DATA_W-1:0] in_exu_res,
    input  logic [DATA_W-1:0] in_load_data,
    input  logic [DATA_W-1:0] in_csr_data,
    input  logic              commit_ready,
    output logic              out_valid,
    output logic              gpr_wen,
    output logic [REG_AW-1:0] gpr_waddr,
    output logic [DATA_W-1:0] gpr_wdata,
    output logic [DATA_W-1:0] retire_pc,
    output logic [CNT_W-1:0]  retire_cnt
);
    import wbu_stage_pkg::*;

    localparam int unsigned ENTRY_W = 2 * DATA_W + REG_AW + 1;

    logic [DATA_W-1:0]  wdata_sel;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;
    logic [DATA_W-1:0]  head_pc;
    logic [REG_AW-1:0]  head_rd;
    logic               head_rd_wen;
    logic [DATA_W-1:0]  head_wdata;
    logic               pop;

    // Write-back source select
    always_comb begin
        wdata_sel = in_exu_res;
        case (in_wb_sel)
            WB_SEL_EXU:  wdata_sel = in_exu_res;
            WB_SEL_LOAD: wdata_sel = in_load_data;
            WB_SEL_PC4:  wdata_sel = in_pc + DATA_W'(4);
            WB_SEL_CSR:  wdata_sel = in_csr_data;
            default:     wdata_sel = in_exu_res;
        endcase
    end

    assign entry_in = {in_pc, in_rd, in_rd_wen, wdata_sel};

    wbu_skid_buf #(
        .WIDTH (ENTRY_W)
    ) u_skid_buf (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (entry_in),
        .out_valid (out_valid),
        .out_ready (commit_ready),
        .out_data  (head)
    );

    assign {head_pc, head_rd, head_rd_wen, head_wdata} = head;

    assign pop       = out_valid & commit_ready;
    assign gpr_waddr = head_rd;
    assign gpr_wdata = head_wdata;
    assign retire_pc = head_pc;
    // x0 writes are dropped but the instruction still retires
    assign gpr_wen   = pop & head_rd_wen & (head_rd != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retire_cnt <= '0;
        end else if (pop) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wbu_stage.sv
// Directed self-checking bench for wbu_stage (retire counter narrowed to 4 bits
// so wrap-around is reachable).
module tb_wbu_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] SEL_EXU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_CSR  = 2'b11;

    logic              clk;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pc;
    logic [REG_AW-1:0] in_rd;
    logic              in_rd_wen;
    logic [1:0]        in_wb_sel;
    logic [DATA_W-1:0] in_exu_res;
    logic [DATA_W-1:0] in_load_data;
    logic [DATA_W-1:0] in_csr_data;
    logic              commit_ready;
    logic              out_valid;
    logic              gpr_wen;
    logic [REG_AW-1:0] gpr_waddr;
    logic [DATA_W-1:0] gpr_wdata;
    logic [DATA_W-1:0] retire_pc;
    logic [CNT_W-1:0]  retire_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    wbu_stage #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rd        (in_rd),
        .in_rd_wen    (in_rd_wen),
        .in_wb_sel    (in_wb_sel),
        .in_exu_res   (in_exu_res),
        .in_load_data (in_load_data),
        .in_csr_data  (in_csr_data),
        .commit_ready (commit_ready),
        .out_valid    (out_valid),
        .gpr_wen      (gpr_wen),
        .gpr_waddr    (gpr_waddr),
        .gpr_wdata    (gpr_wdata),
        .retire_pc    (retire_pc),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic wen, input logic [1:0] sel, input logic [31:0] exu,
                         input logic [31:0] ld, input logic [31:0] csr);
        in_valid     = v;
        in_pc        = pc;
        in_rd        = rd;
        in_rd_wen    = wen;
        in_wb_sel    = sel;
        in_exu_res   = exu;
        in_load_data = ld;
        in_csr_data  = csr;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 32'h0, 5'd0, 1'b0, SEL_EXU, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        commit_ready = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++;
        if (gpr_wen !== 1'b0) begin tests_failed++; $display("FAIL reset_gpr_wen got=%b exp=0", gpr_wen); end
        tests_run++;
        if (retire_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_retire_cnt got=%0d exp=0", retire_cnt); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || gpr_wen !== 1'b0 || retire_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL idle_after_reset got ready=%b valid=%b wen=%b cnt=%0d exp 1 0 0 0",
                     in_ready, out_valid, gpr_wen, retire_cnt);
        end
    endtask

    task automatic test_single_load();
        @(negedge clk);
        commit_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 5'd5, 1'b1, SEL_LOAD, 32'h1111_1111, 32'hFFFF_FF80, 32'h2222_2222);
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || gpr_wen !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_strobe got valid=%b wen=%b exp 1 1", out_valid, gpr_wen);
        end
        tests_run++;
        if (gpr_waddr !== 5'd5) begin tests_failed++; $display("FAIL load_waddr got=%0d exp=5", gpr_waddr); end
        tests_run++;
        if (gpr_wdata !== 32'hFFFF_FF80) begin tests_failed++; $display("FAIL load_wdata got=%h exp=ffffff80", gpr_wdata); end
        tests_run++;
        if (retire_pc !== 32'h8000_0000) begin tests_failed++; $display("FAIL load_retire_pc got=%h exp=80000000", retire_pc); end
        @(negedge clk);
        #1;
        tests_run++;
        if (retire_cnt !== 4'd1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_retired got cnt=%0d valid=%b exp 1 0", retire_cnt, out_valid);
        end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        commit_ready = 1'b0;
        drive(1'b1, 32'h0000_0100, 5'd1, 1'b1, SEL_PC4, 32'hAAAA_AAAA, 32'h0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_second got=%b exp=1", in_ready); end
        drive(1'b1, 32'h0000_0200, 5'd2, 1'b1, SEL_EXU, 32'h0000_1234, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        tests_run++;
        if (gpr_wen !== 1'b0 || gpr_wdata !== 32'h0000_0104) begin
            tests_failed++;
            $display("FAIL bp_hold got wen=%b wdata=%h exp 0 00000104", gpr_wen, gpr_wdata);
        end
        drive(1'b1, 32'h0000_0999, 5'd3, 1'b1, SEL_EXU, 32'h0000_0BAD, 32'h0, 32'h0);
        @(negedge clk);
        idle_inputs();
        commit_ready = 1'b1;
        #1;
        tests_run++;
        if (gpr_wen !== 1'b1 || gpr_wdata !== 32'h0000_0104 || gpr_waddr !== 5'd1) begin
            tests_failed++;
            $display("FAIL bp_pop1 got wen=%b waddr=%0d wdata=%h exp 1 1 00000104", gpr_wen, gpr_waddr, gpr_wdata);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_return got=%b exp=1", in_ready); end
        tests_run++;
        if (gpr_wen !== 1'b1 || gpr_wdata !== 32'h0000_1234 || retire_pc !== 32'h0000_0200) begin
            tests_failed++;
            $display("FAIL bp_pop2 got wen=%b wdata=%h pc=%h exp 1 00001234 00000200", gpr_wen, gpr_wdata, retire_pc);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || retire_cnt !== 4'd3) begin
            tests_failed++;
            $display("FAIL bp_third_rejected got valid=%b cnt=%0d exp 0 3", out_valid, retire_cnt);
        end
    endtask

    task automatic test_x0_write();
        @(negedge clk);
        commit_ready = 1'b1;
        drive(1'b1, 32'h0000_0300, 5'd0, 1'b1, SEL_CSR, 32'h0, 32'h0, 32'h0000_DEAD);
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || gpr_wen !== 1'b0 || gpr_wdata !== 32'h0000_DEAD) begin
            tests_failed++;
            $display("FAIL x0_suppress got valid=%b wen=%b wdata=%h exp 1 0 0000dead", out_valid, gpr_wen, gpr_wdata);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (retire_cnt !== 4'd4) begin tests_failed++; $display("FAIL x0_retire_cnt got=%0d exp=4", retire_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data;
        logic [31:0] exp_pc;
        do_reset();
        commit_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_data = 32'(i - 1) * 32'd3 + 32'd7;
                exp_pc   = 32'h2000 + 32'(i - 1) * 32'd4;
                #1;
                tests_run++;
                if (out_valid !== 1'b1 || gpr_wen !== 1'b1 || in_ready !== 1'b1 ||
                    gpr_wdata !== exp_data || retire_pc !== exp_pc) begin
                    tests_failed++;
                    $display("FAIL stream_%0d got valid=%b wen=%b ready=%b wdata=%h pc=%h exp 1 1 1 %h %h",
                             i - 1, out_valid, gpr_wen, in_ready, gpr_wdata, retire_pc, exp_data, exp_pc);
                end
            end
            drive(1'b1, 32'h2000 + 32'(i) * 32'd4, 5'(i % 31 + 1), 1'b1, SEL_EXU,
                  32'(i) * 32'd3 + 32'd7, 32'h0, 32'h0);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || gpr_wdata !== 32'd64) begin
            tests_failed++;
            $display("FAIL stream_19 got valid=%b wdata=%h exp 1 00000040", out_valid, gpr_wdata);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (retire_cnt !== 4'd4 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_wrap got cnt=%0d valid=%b exp 4 0", retire_cnt, out_valid);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        commit_ready = 1'b0;
        drive(1'b1, 32'h0000_0400, 5'd7, 1'b1, SEL_EXU, 32'h0000_0077, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b1, 32'h0000_0404, 5'd8, 1'b1, SEL_EXU, 32'h0000_0088, 32'h0, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL ar_full_before got ready=%b valid=%b exp 0 1", in_ready, out_valid);
        end
        #1;
        rstn = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || gpr_wen !== 1'b0 || retire_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL ar_immediate got valid=%b ready=%b wen=%b cnt=%0d exp 0 1 0 0",
                     out_valid, in_ready, gpr_wen, retire_cnt);
        end
        @(negedge clk);
        commit_ready = 1'b1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (gpr_wen !== 1'b0 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL ar_quiet_%0d got wen=%b valid=%b exp 0 0", i, gpr_wen, out_valid);
            end
        end
        drive(1'b1, 32'h0000_0500, 5'd9, 1'b1, SEL_EXU, 32'h0000_0099, 32'h0, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (gpr_wen !== 1'b1 || gpr_wdata !== 32'h0000_0099 || gpr_waddr !== 5'd9) begin
            tests_failed++;
            $display("FAIL ar_new_push got wen=%b waddr=%0d wdata=%h exp 1 9 00000099", gpr_wen, gpr_waddr, gpr_wdata);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (retire_cnt !== 4'd1) begin tests_failed++; $display("FAIL ar_cnt got=%0d exp=1", retire_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_back_pressure();
        test_x0_write();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
